// File: rtl/shift_normalize_pkg.sv
// Shared types and helpers for the iterative leading-zero normalizer.
package shift_normalize_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } norm_state_t;

  // Width of the bit group examined by search step k.
  function automatic int unsigned step_width(input int unsigned k);
    return 32'd1 << k;
  endfunction

endpackage

// File: rtl/shift_normalize_stage.sv
// One binary-search step: shift out the top 2^k bits when they are all zero.
module shift_normalize_stage
  import shift_normalize_pkg::*;
#(
  parameter  int WIDTH     = 32,
  localparam int LOG2      = $clog2(WIDTH),
  localparam int CNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]     data,
  input  logic [CNT_WIDTH-1:0] cnt,
  input  logic [LOG2-1:0]      k,
  output logic [WIDTH-1:0]     next_data,
  output logic [CNT_WIDTH-1:0] next_cnt
);

  logic [CNT_WIDTH-1:0] w_s;
  logic [WIDTH-1:0]     mask_s;

  // Examine the top 2^k bits and shift them out when they are all zero.
  always_comb begin
    w_s    = CNT_WIDTH'(step_width(32'(k)));
    mask_s = ~({WIDTH{1'b1}} >> w_s);
    if ((data & mask_s) == {WIDTH{1'b0}}) begin
      next_data = data << w_s;
      next_cnt  = cnt + w_s;
    end else begin
      next_data = data;
      next_cnt  = cnt;
    end
  end

endmodule

// File: rtl/shift_normalize.sv
// Iterative leading-zero normalizer with valid/ready on both sides.
// Optional SHIFT_NORMALIZE_EARLY_EXIT_EN: zero or MSB-set words finish in one step.
module shift_normalize
  import shift_normalize_pkg::*;
#(
  parameter  int WIDTH     = 32,
  localparam int LOG2      = $clog2(WIDTH),
  localparam int CNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_WIDTH-1:0] out_cnt,
  output logic                 out_zero
);

  localparam logic [LOG2-1:0]      K_LAST   = LOG2'(LOG2 - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(WIDTH);

  norm_state_t          state_r;
  norm_state_t          state_s;
  logic [WIDTH-1:0]     data_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 zero_r;
  logic [LOG2-1:0]      k_r;
  logic [LOG2-1:0]      k_init_s;
  logic                 early_s;
  logic                 accept_s;
  logic [WIDTH-1:0]     step_data_s;
  logic [CNT_WIDTH-1:0] step_cnt_s;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic [WIDTH-1:0]     out_data_r;
  logic [CNT_WIDTH-1:0] out_cnt_r;
  logic                 out_zero_r;

`ifdef SHIFT_NORMALIZE_EARLY_EXIT_EN
  // A zero word or one with the MSB set needs only the final 1-bit step.
  assign early_s = (in_data == {WIDTH{1'b0}}) || in_data[WIDTH-1];
`else
  assign early_s = 1'b0;
`endif

  assign accept_s = in_valid && in_ready_r;
  assign k_init_s = early_s ? {LOG2{1'b0}} : K_LAST;

  shift_normalize_stage #(.WIDTH(WIDTH)) u_stage (
    .data      (data_r),
    .cnt       (cnt_r),
    .k         (k_r),
    .next_data (step_data_s),
    .next_cnt  (step_cnt_s)
  );

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = RUN;
        else          state_s = IDLE;
      end
      RUN: begin
        if (k_r == {LOG2{1'b0}}) state_s = DONE;
        else                     state_s = RUN;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, search registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      data_r      <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_WIDTH{1'b0}};
      zero_r      <= 1'b0;
      k_r         <= {LOG2{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_cnt_r   <= {CNT_WIDTH{1'b0}};
      out_zero_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= (state_s == IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            data_r <= in_data;
            cnt_r  <= {CNT_WIDTH{1'b0}};
            zero_r <= (in_data == {WIDTH{1'b0}});
            k_r    <= k_init_s;
          end
        end
        RUN: begin
          data_r <= step_data_s;
          cnt_r  <= step_cnt_s;
          if (k_r == {LOG2{1'b0}}) begin
            // The search of a zero word sums to WIDTH-1, so the count is overridden.
            out_valid_r <= 1'b1;
            out_data_r  <= step_data_s;
            out_cnt_r   <= zero_r ? CNT_FULL : step_cnt_s;
            out_zero_r  <= zero_r;
          end else begin
            k_r <= k_r - LOG2'(1);
          end
        end
        DONE: begin
          if (out_ready) out_valid_r <= 1'b0;
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_cnt   = out_cnt_r;
  assign out_zero  = out_zero_r;

endmodule

// File: tb/tb_shift_normalize.sv
// Self-checking bench for shift_normalize: directed cases, stalls, reset abort, random words.
module tb_shift_normalize;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  cnt;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_cnt;
  logic        out_zero;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  shift_normalize #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] d);
    exp_t e;
    int   n;
    n = 32;
    for (int i = 0; i < 32; i++) if (d[i]) n = 31 - i;
    e.cnt  = 6'(n);
    e.zero = (d == 32'd0);
    e.data = (n == 32) ? 32'd0 : (d << n);
    return e;
  endfunction

  function automatic int exp_lat(input logic [31:0] d);
`ifdef SHIFT_NORMALIZE_EARLY_EXIT_EN
    return ((d == 32'd0) || d[31]) ? 1 : 5;
`else
    return 5;
`endif
  endfunction

  // Present a word until accepted; pushes the expected result on acceptance.
  task automatic send(input logic [31:0] d, output int ok);
    ok       = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 60 && ok == 0; i++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1;
        q.push_back(model(d));
      end else begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid; -1 when the bound expires.
  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (out_valid) lat = i;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    n_checks++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
    n_checks++; if (out_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", out_cnt); end
    n_checks++; if (out_zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero got %0b want 0", out_zero); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_normalize();
    logic [31:0] words [7];
    exp_t        e;
    int          ok;
    int          lat;
    words = '{32'h0001_0000, 32'h0000_0000, 32'h8000_0001, 32'h0000_0001,
              32'hFFFF_FFFF, 32'h0000_0F00, 32'h4000_0000};
    foreach (words[i]) begin
      send(words[i], ok);
      n_checks++; if (ok != 1) begin n_fail++; $display("FAIL norm_accept word %h not accepted", words[i]); end
      wait_out(lat);
      n_checks++; if (lat != exp_lat(words[i])) begin n_fail++; $display("FAIL norm_latency word %h got %0d want %0d", words[i], lat, exp_lat(words[i])); end
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++; if (out_cnt !== e.cnt) begin n_fail++; $display("FAIL norm_cnt word %h got %0d want %0d", words[i], out_cnt, e.cnt); end
        n_checks++; if (out_data !== e.data) begin n_fail++; $display("FAIL norm_data word %h got %h want %h", words[i], out_data, e.data); end
        n_checks++; if (out_zero !== e.zero) begin n_fail++; $display("FAIL norm_zero word %h got %0b want %0b", words[i], out_zero, e.zero); end
      end
      handshake();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL norm_drop got %0b want 0", out_valid); end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    int   ok;
    int   lat;
    send(32'h0000_0001, ok);
    wait_out(lat);
    n_checks++; if (lat != 5) begin n_fail++; $display("FAIL stall_latency got %0d want 5", lat); end
    e = q.pop_front();
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_hold cycle %0d valid %0b ready %0b want 1 0", i, out_valid, in_ready); end
      n_checks++; if (out_cnt !== 6'd31 || out_data !== 32'h8000_0000) begin n_fail++; $display("FAIL stall_value cycle %0d got %0d %h want 31 80000000", i, out_cnt, out_data); end
      @(posedge clk); #1;
    end
    n_checks++; if (out_cnt !== e.cnt) begin n_fail++; $display("FAIL stall_model got %0d want %0d", out_cnt, e.cnt); end
    handshake();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release ready %0b valid %0b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_out_ready_early();
    exp_t e;
    int   ok;
    int   lat;
    out_ready = 1'b1;
    send(32'h0000_4000, ok);
    wait_out(lat);
    n_checks++; if (lat != 5) begin n_fail++; $display("FAIL early_ready_latency got %0d want 5", lat); end
    e = q.pop_front();
    n_checks++; if (out_cnt !== e.cnt || out_data !== e.data) begin n_fail++; $display("FAIL early_ready_result got %0d %h want %0d %h", out_cnt, out_data, e.cnt, e.data); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL early_ready_once got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int   ok;
    int   lat;
    int   seen;
    send(32'h0000_0F00, ok);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_state ready %0b valid %0b want 1 0", in_ready, out_valid); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_result got %0d valid cycles want 0", seen); end
    send(32'h00F0_0000, ok);
    wait_out(lat);
    n_checks++; if (lat != 5) begin n_fail++; $display("FAIL abort_next_latency got %0d want 5", lat); end
    e = q.pop_front();
    n_checks++; if (out_cnt !== e.cnt || out_data !== e.data) begin n_fail++; $display("FAIL abort_next_result got %0d %h want %0d %h", out_cnt, out_data, e.cnt, e.data); end
    handshake();
  endtask

  task automatic test_random();
    exp_t        e;
    logic [31:0] d;
    int          ok;
    int          lat;
    for (int n = 0; n < 3000; n++) begin
      d = $urandom();
      if ($urandom_range(0, 3) != 0) d = d >> $urandom_range(0, 31);
      if ($urandom_range(0, 63) == 0) d = 32'd0;
      send(d, ok);
      wait_out(lat);
      n_checks++; if (lat != exp_lat(d)) begin n_fail++; $display("FAIL rand_latency word %h got %0d want %0d", d, lat, exp_lat(d)); end
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rand_hold word %h valid %0b want 1", d, out_valid); end
        n_checks++; if (out_cnt !== e.cnt) begin n_fail++; $display("FAIL rand_cnt word %h got %0d want %0d", d, out_cnt, e.cnt); end
        n_checks++; if (out_data !== e.data || out_zero !== e.zero) begin n_fail++; $display("FAIL rand_data word %h got %h/%0b want %h/%0b", d, out_data, out_zero, e.data, e.zero); end
      end
      handshake();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_once word %h valid %0b want 0", d, out_valid); end
    end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_queue got %0d pending want 0", q.size()); end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    test_reset();
    test_normalize();
    test_stall();
    test_out_ready_early();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
